control_unit: RTL and testbench

//  Hardwired Moore FSM that sequences the DataPath through fetch (T0-T2) and execute (T3-T7).

---
 rtl/control_unit_if.sv | 37 +++
 rtl/control_unit.sv | 201 ++++++++++++++++++++
 tb/tb_control_unit.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: DataPath <-> control unit bundle (ir, mem_ready, stop in;
// strobes, alu_op, run, illegal out). master = control unit, slave = DataPath.
interface control_unit_if #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
);
  logic [IR_W-1:0] ir;
  logic mem_ready, stop;
  logic read, write, MDRin, MDRout, MARin;
  logic PCin, PCout, IncPC, IRin;
  logic Gra, Grb, Grc, Rin, Rout;
  logic BAout, Cout, Yin, Zin;
  logic Zhighout, Zlowout, HIin, HIout;
  logic LOin, LOout;
  logic [OP_W-1:0] alu_op;
  logic run, illegal;

  modport master (
    input  ir, mem_ready, stop,
    output read, write, MDRin, MDRout, MARin,
    output PCin, PCout, IncPC, IRin,
    output Gra, Grb, Grc, Rin, Rout,
    output BAout, Cout, Yin, Zin,
    output Zhighout, Zlowout, HIin, HIout,
    output LOin, LOout, alu_op, run, illegal
  );

  modport slave (
    output ir, mem_ready, stop,
    input  read, write, MDRin, MDRout, MARin,
    input  PCin, PCout, IncPC, IRin,
    input  Gra, Grb, Grc, Rin, Rout,
    input  BAout, Cout, Yin, Zin,
    input  Zhighout, Zlowout, HIin, HIout,
    input  LOin, LOout, alu_op, run, illegal
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch (T0-T2) and execute (T3-T7).
// Ports: clock, clear (async low), bus (control_unit_if.master); step with CU_STEP_MODE_EN.
module control_unit #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input logic clock,
  input logic clear,
`ifdef CU_STEP_MODE_EN
  input logic step,
`endif
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7,
    HALT, STEP_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [OP_W-1:0] op_q, opc;
  logic is_ld, is_ldi, is_st, is_alu, is_md;
  logic is_mfhi, is_mflo, is_jr, is_nop;
  logic is_halt, is_ill, is_mem;
  logic last;

  wire unused_ir = ^bus.ir[IR_W-OP_W-1:0];

  // ir is only valid from T3; decode it live in T3, then from the copy.
  assign opc = (state_q == T3) ? bus.ir[IR_W-1 -: OP_W] : op_q;

  assign is_ld   = opc == OP_W'(0);
  assign is_ldi  = opc == OP_W'(1);
  assign is_st   = opc == OP_W'(2);
  assign is_alu  = opc inside {OP_W'(3), OP_W'(4), OP_W'(5), OP_W'(6)};
  assign is_md   = opc inside {OP_W'(15), OP_W'(16)};
  assign is_mfhi = opc == OP_W'(23);
  assign is_mflo = opc == OP_W'(24);
  assign is_jr   = opc == OP_W'(21);
  assign is_nop  = opc == OP_W'(26);
  assign is_halt = opc == OP_W'(27);
  assign is_mem  = is_ld | is_ldi | is_st;
  assign is_ill  = ~(is_mem | is_alu | is_md | is_mfhi |
                     is_mflo | is_jr | is_nop | is_halt);

`ifdef CU_STEP_MODE_EN
  logic [2:0] step_sync;
  logic step_rise;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) step_sync <= '0;
    else        step_sync <= {step_sync[1:0], step};
  end

  // One-cycle pulse; ignored unless the FSM sits in STEP_WAIT.
  assign step_rise = step_sync[1] & ~step_sync[2];
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= RESET;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T3) op_q <= bus.ir[IR_W-1 -: OP_W];
    end
  end

  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    unique case (state_q)
      RESET: state_d = T0;
      T0:    state_d = T1;
      T1:    if (bus.mem_ready) state_d = T2;
      T2:    state_d = T3;
      T3: begin
        unique case (1'b1)
          is_halt: state_d = HALT;
          is_mem, is_alu, is_md: state_d = T4;
          default: last = 1'b1;
        endcase
      end
      T4: state_d = T5;
      T5: begin
        if (is_ldi || is_alu) last = 1'b1;
        else                  state_d = T6;
      end
      T6: begin
        if (is_md)                  last = 1'b1;
        else if (is_st)             state_d = T7;
        else if (bus.mem_ready)     state_d = T7;
      end
      T7: if (is_ld || bus.mem_ready) last = 1'b1;
      HALT: state_d = HALT;
`ifdef CU_STEP_MODE_EN
      STEP_WAIT: begin
        if (bus.stop)       state_d = HALT;
        else if (step_rise) state_d = T0;
      end
`endif
      default: state_d = RESET;
    endcase
    if (last) begin
`ifdef CU_STEP_MODE_EN
      state_d = bus.stop ? HALT : STEP_WAIT;
`else
      state_d = bus.stop ? HALT : T0;
`endif
    end
  end

  always_comb begin
    bus.read = 1'b0;  bus.write = 1'b0;
    bus.MDRin = 1'b0; bus.MDRout = 1'b0;
    bus.MARin = 1'b0; bus.PCin = 1'b0;
    bus.PCout = 1'b0; bus.IncPC = 1'b0;
    bus.IRin = 1'b0;  bus.Gra = 1'b0;
    bus.Grb = 1'b0;   bus.Grc = 1'b0;
    bus.Rin = 1'b0;   bus.Rout = 1'b0;
    bus.BAout = 1'b0; bus.Cout = 1'b0;
    bus.Yin = 1'b0;   bus.Zin = 1'b0;
    bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
    bus.HIin = 1'b0;  bus.HIout = 1'b0;
    bus.LOin = 1'b0;  bus.LOout = 1'b0;
    bus.alu_op = '0;
    bus.illegal = 1'b0;
    bus.run = state_q inside {T0, T1, T2, T3, T4, T5, T6, T7};
    unique case (state_q)
      T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
      end
      T1: begin
        bus.read = 1'b1; bus.MDRin = 1'b1; bus.PCin = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      T3: begin
        unique case (1'b1)
          is_mem: begin
            bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
          end
          is_alu: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end
          is_md: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end
          is_mfhi: begin
            bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          is_mflo: begin
            bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          is_jr: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
          end
          is_nop, is_halt: ;
          is_ill: bus.illegal = 1'b1;
        endcase
      end
      T4: begin
        if (is_mem) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_W'(3);
        end else if (is_alu) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
          bus.alu_op = opc;
        end else if (is_md) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
          bus.alu_op = opc;
        end
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (is_ld || is_st) bus.MARin = 1'b1;
        else if (is_md)     bus.LOin = 1'b1;
        else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      T6: begin
        if (is_md) begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        end else if (is_st) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end else begin
          bus.read = 1'b1; bus.MDRin = 1'b1;
        end
      end
      T7: begin
        if (is_st) bus.write = 1'b1;
        else begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit.
// Expected per-cycle output words are queued with their stimulus.
module tb_control_unit;
  localparam int IR_W = 32;
  localparam int OP_W = 5;

  localparam logic [30:0] READ   = 31'd1 << 30;
  localparam logic [30:0] WRITE  = 31'd1 << 29;
  localparam logic [30:0] MDRIN  = 31'd1 << 28;
  localparam logic [30:0] MDROUT = 31'd1 << 27;
  localparam logic [30:0] MARIN  = 31'd1 << 26;
  localparam logic [30:0] PCIN   = 31'd1 << 25;
  localparam logic [30:0] PCOUT  = 31'd1 << 24;
  localparam logic [30:0] INCPC  = 31'd1 << 23;
  localparam logic [30:0] IRIN   = 31'd1 << 22;
  localparam logic [30:0] GRA    = 31'd1 << 21;
  localparam logic [30:0] GRB    = 31'd1 << 20;
  localparam logic [30:0] GRC    = 31'd1 << 19;
  localparam logic [30:0] RIN    = 31'd1 << 18;
  localparam logic [30:0] ROUT   = 31'd1 << 17;
  localparam logic [30:0] BAOUT  = 31'd1 << 16;
  localparam logic [30:0] COUT   = 31'd1 << 15;
  localparam logic [30:0] YIN    = 31'd1 << 14;
  localparam logic [30:0] ZIN    = 31'd1 << 13;
  localparam logic [30:0] ZHI    = 31'd1 << 12;
  localparam logic [30:0] ZLO    = 31'd1 << 11;
  localparam logic [30:0] HIIN   = 31'd1 << 10;
  localparam logic [30:0] HIOUT  = 31'd1 << 9;
  localparam logic [30:0] LOIN   = 31'd1 << 8;
  localparam logic [30:0] LOOUT  = 31'd1 << 7;
  localparam logic [30:0] RUN    = 31'd1 << 1;
  localparam logic [30:0] ILL    = 31'd1;

  typedef struct {
    logic [63:0]     tag;
    logic [30:0]     exp;
    logic            mr;
    logic            st;
    logic            cl;
    logic [IR_W-1:0] ir;
  } step_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic [IR_W-1:0] cur_ir = '0;
  step_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clock = ~clock;

  control_unit_if #(.IR_W(IR_W), .OP_W(OP_W)) bus ();

  control_unit #(.IR_W(IR_W), .OP_W(OP_W)) dut (
    .clock(clock),
    .clear(clear),
    .bus(bus)
  );

  wire [30:0] obs = {
    bus.read, bus.write, bus.MDRin, bus.MDRout, bus.MARin,
    bus.PCin, bus.PCout, bus.IncPC, bus.IRin,
    bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
    bus.BAout, bus.Cout, bus.Yin, bus.Zin,
    bus.Zhighout, bus.Zlowout, bus.HIin, bus.HIout,
    bus.LOin, bus.LOout, bus.alu_op, bus.run, bus.illegal
  };

  function automatic logic [30:0] aop(input logic [4:0] o);
    return {24'd0, o, 2'b00};
  endfunction

  function automatic logic [IR_W-1:0] mk(input logic [4:0] o);
    return {o, 27'h0123456};
  endfunction

  task automatic push(input logic [63:0] tag, input logic [30:0] e,
                      input logic mr = 1'b1, input logic st = 1'b0,
                      input logic cl = 1'b1);
    step_t s;
    s.tag = tag; s.exp = e; s.mr = mr;
    s.st = st; s.cl = cl; s.ir = cur_ir;
    sb.push_back(s);
  endtask

  task automatic push_reset();
    push("rst", '0, 1'b1, 1'b0, 1'b0);
    push("rel", '0);
  endtask

  task automatic push_fetch();
    push("t0", PCOUT | MARIN | INCPC | RUN);
    push("t1", READ | MDRIN | PCIN | RUN);
    push("t2", MDROUT | IRIN | RUN);
  endtask

  task automatic apply_next(output step_t s);
    s = sb.pop_front();
    @(negedge clock);
    clear = s.cl;
    bus.mem_ready = s.mr;
    bus.stop = s.st;
    bus.ir = s.ir;
    #1;
  endtask

  task automatic test_reset();
    step_t s;
    push("rst", '0, 1'b1, 1'b0, 1'b0);
    push_reset();
    cur_ir = mk(5'b11010);
    push_fetch();
    push("nop3", RUN);
    push("t0", PCOUT | MARIN | INCPC | RUN);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL reset/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_alu();
    step_t s;
    logic [4:0] ops [4];
    ops[0] = 5'b00011; ops[1] = 5'b00100;
    ops[2] = 5'b00101; ops[3] = 5'b00110;
    push_reset();
    for (int i = 0; i < 4; i++) begin
      cur_ir = (i == 0) ? 32'h18A00000 : mk(ops[i]);
      push_fetch();
      push("a3", GRB | ROUT | YIN | RUN);
      push("a4", GRC | ROUT | ZIN | aop(ops[i]) | RUN, 1'b1, i == 1);
      push("a5", ZLO | GRA | RIN | RUN);
    end
    push("t0", PCOUT | MARIN | INCPC | RUN);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL alu/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_load();
    step_t s;
    push_reset();
    cur_ir = mk(5'b00000);
    push_fetch();
    push("ld3", GRB | BAOUT | YIN | RUN);
    push("ld4", COUT | ZIN | aop(5'b00011) | RUN);
    push("ld5", ZLO | MARIN | RUN);
    for (int i = 0; i < 3; i++)
      push("ld6s", READ | MDRIN | RUN, 1'b0);
    push("ld6", READ | MDRIN | RUN);
    push("ld7", MDROUT | GRA | RIN | RUN);
    cur_ir = mk(5'b00001);
    push("t0", PCOUT | MARIN | INCPC | RUN);
    push("t1s", READ | MDRIN | PCIN | RUN, 1'b0);
    push("t1", READ | MDRIN | PCIN | RUN);
    push("t2", MDROUT | IRIN | RUN);
    push("ldi3", GRB | BAOUT | YIN | RUN);
    push("ldi4", COUT | ZIN | aop(5'b00011) | RUN);
    push("ldi5", ZLO | GRA | RIN | RUN);
    push("t0", PCOUT | MARIN | INCPC | RUN);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL load/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_store();
    step_t s;
    push_reset();
    cur_ir = mk(5'b00010);
    push_fetch();
    push("st3", GRB | BAOUT | YIN | RUN);
    push("st4", COUT | ZIN | aop(5'b00011) | RUN);
    push("st5", ZLO | MARIN | RUN);
    push("st6", GRA | ROUT | MDRIN | RUN, 1'b0);
    push("st7s", WRITE | RUN, 1'b0);
    push("st7", WRITE | RUN);
    push("t0", PCOUT | MARIN | INCPC | RUN);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL store/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_muldiv();
    step_t s;
    logic [4:0] ops [2];
    ops[0] = 5'b01111; ops[1] = 5'b10000;
    push_reset();
    for (int i = 0; i < 2; i++) begin
      cur_ir = mk(ops[i]);
      push_fetch();
      push("m3", GRA | ROUT | YIN | RUN);
      push("m4", GRB | ROUT | ZIN | aop(ops[i]) | RUN);
      push("m5", ZLO | LOIN | RUN);
      push("m6", ZHI | HIIN | RUN);
    end
    push("t0", PCOUT | MARIN | INCPC | RUN);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL muldiv/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_single();
    step_t s;
    push_reset();
    cur_ir = mk(5'b10111);
    push_fetch();
    push("mfhi", HIOUT | GRA | RIN | RUN);
    cur_ir = mk(5'b11000);
    push_fetch();
    push("mflo", LOOUT | GRA | RIN | RUN);
    cur_ir = mk(5'b10101);
    push_fetch();
    push("jr", GRA | ROUT | PCIN | RUN);
    cur_ir = mk(5'b01000);
    push_fetch();
    push("ill8", ILL | RUN);
    cur_ir = mk(5'b11111);
    push_fetch();
    push("ill31", ILL | RUN);
    cur_ir = mk(5'b11010);
    push_fetch();
    push("nop", RUN);
    push("t0", PCOUT | MARIN | INCPC | RUN);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL single/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_halt();
    step_t s;
    push_reset();
    cur_ir = mk(5'b11011);
    push_fetch();
    push("hlt3", RUN);
    push("hlt", '0, 1'b0);
    push("hlt", '0, 1'b1, 1'b1);
    push("hlt", '0);
    push_reset();
    cur_ir = mk(5'b11000);
    push_fetch();
    push("flo3", LOOUT | GRA | RIN | RUN, 1'b1, 1'b1);
    push("stp", '0);
    push("stp", '0);
    push_reset();
    cur_ir = mk(5'b11011);
    push_fetch();
    push("hs3", RUN, 1'b1, 1'b1);
    push("hs", '0);
    push("hs", '0);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL halt/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_clear_mid();
    step_t s;
    push_reset();
    cur_ir = mk(5'b00010);
    push_fetch();
    push("st3", GRB | BAOUT | YIN | RUN);
    push("st4", COUT | ZIN | aop(5'b00011) | RUN);
    push("st5", ZLO | MARIN | RUN);
    push("clr6", '0, 1'b1, 1'b0, 1'b0);
    push("rel", '0);
    cur_ir = mk(5'b11010);
    push_fetch();
    push("nop", RUN);
    push("t0", PCOUT | MARIN | INCPC | RUN);
    while (sb.size() != 0) begin
      apply_next(s);
      n_cmp++;
      if (obs !== s.exp) begin
        n_mis++;
        $display("FAIL clrmid/%s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ir = '0;
    bus.mem_ready = 1'b1;
    bus.stop = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_muldiv();
    test_single();
    test_halt();
    test_clear_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
